v_mac_multichan: RTL and testbench

Parametrised multi-channel multiply-accumulate with up/down control, registered after multiplication, and fully pipelined at one operation per clock. Each sample carries a channel index and updates one of CHANNELS independent accumulators. Per-operation controls cover clear-and-load, signed/unsigned mode, and optional saturation with an overflow flag. Used wherever the single-channel up/down MAC is too narrow or needs several running sums.

---
 rtl/v_mac_multichan.sv | 161 ++++++++++++++++
 tb/tb_v_mac_multichan.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v_mac_multichan.sv
// Multi-channel multiply-accumulate: 3-stage pipeline (input regs, product regs,
// per-channel read-modify-write) with add/subtract, clear-and-load and optional saturation.
module v_mac_multichan #(
   parameter int WA       = 8,
   parameter int WB       = 8,
   parameter int WACC     = 20,
   parameter int CHANNELS = 4,
   parameter int CW       = 2,
   parameter bit SIGNED   = 1'b0,
   parameter bit SATURATE = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [CW-1:0]   ch,
   input  logic            add_sub,
   input  logic            clr,
   input  logic [WA-1:0]   A,
   input  logic [WB-1:0]   B,
   output logic            out_valid,
   output logic [CW-1:0]   ch_out,
   output logic [WACC-1:0] RES,
   output logic            ovf
);

   localparam logic [CW:0] CH_LIMIT = (CW+1)'(CHANNELS);

   // Stage 1: sampled operands and controls
   logic            s1_valid_q, s1_valid_d;
   logic [WA-1:0]   s1_a_q, s1_a_d;
   logic [WB-1:0]   s1_b_q, s1_b_d;
   logic [CW-1:0]   s1_ch_q, s1_ch_d;
   logic            s1_add_q, s1_add_d;
   logic            s1_clr_q, s1_clr_d;

   // Stage 2: extended product and controls
   logic            s2_valid_q, s2_valid_d;
   logic [WACC-1:0] s2_prod_q, s2_prod_d;
   logic [CW-1:0]   s2_ch_q, s2_ch_d;
   logic            s2_add_q, s2_add_d;
   logic            s2_clr_q, s2_clr_d;

   // Stage 3: accumulators and result registers
   logic [WACC-1:0] acc_q [CHANNELS];
   logic [WACC-1:0] acc_d [CHANNELS];
   logic            out_valid_q, out_valid_d;
   logic [CW-1:0]   ch_out_q, ch_out_d;
   logic [WACC-1:0] res_q, res_d;
   logic            ovf_q, ovf_d;

   logic [WACC-1:0] a_w, b_w, base, clamp, result;
   logic [WACC:0]   base_x, prod_x, sum;
   logic            over;

   // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
   always_comb begin
      // Out-of-range channels are dropped here; the bubble still flows down the pipe.
      s1_valid_d = in_valid && ({1'b0, ch} < CH_LIMIT);
      s1_a_d     = A;
      s1_b_d     = B;
      s1_ch_d    = ch;
      s1_add_d   = add_sub;
      s1_clr_d   = clr;
   end

   always_comb begin
      // Widening before the multiply keeps the low WACC bits exact in both modes.
      if (SIGNED) begin
         a_w = WACC'($signed(s1_a_q));
         b_w = WACC'($signed(s1_b_q));
      end else begin
         a_w = WACC'(s1_a_q);
         b_w = WACC'(s1_b_q);
      end
      s2_prod_d  = a_w * b_w;
      s2_valid_d = s1_valid_q;
      s2_ch_d    = s1_ch_q;
      s2_add_d   = s1_add_q;
      s2_clr_d   = s1_clr_q;
   end

   always_comb begin
      base = s2_clr_q ? '0 : acc_q[s2_ch_q];
      if (SIGNED) begin
         base_x = {base[WACC-1], base};
         prod_x = {s2_prod_q[WACC-1], s2_prod_q};
      end else begin
         base_x = {1'b0, base};
         prod_x = {1'b0, s2_prod_q};
      end
      sum = s2_add_q ? (base_x + prod_x) : (base_x - prod_x);

      if (SIGNED) begin
         over  = sum[WACC] ^ sum[WACC-1];
         clamp = sum[WACC] ? {1'b1, {(WACC-1){1'b0}}} : {1'b0, {(WACC-1){1'b1}}};
      end else begin
         // Carry on add or borrow on subtract both land in the extra bit.
         over  = sum[WACC];
         clamp = s2_add_q ? '1 : '0;
      end
      result = (over && SATURATE) ? clamp : sum[WACC-1:0];

      acc_d       = acc_q;
      out_valid_d = s2_valid_q;
      ch_out_d    = ch_out_q;
      res_d       = res_q;
      ovf_d       = ovf_q;
      if (s2_valid_q) begin
         acc_d[s2_ch_q] = result;
         ch_out_d       = s2_ch_q;
         res_d          = result;
         ovf_d          = over;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_ch_q     <= '0;
         s1_add_q    <= 1'b0;
         s1_clr_q    <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_prod_q   <= '0;
         s2_ch_q     <= '0;
         s2_add_q    <= 1'b0;
         s2_clr_q    <= 1'b0;
         // NOTE: the accumulator array is architectural state that must read 0 after reset, so it is reset here.
         for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
         out_valid_q <= 1'b0;
         ch_out_q    <= '0;
         res_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_ch_q     <= s1_ch_d;
         s1_add_q    <= s1_add_d;
         s1_clr_q    <= s1_clr_d;
         s2_valid_q  <= s2_valid_d;
         s2_prod_q   <= s2_prod_d;
         s2_ch_q     <= s2_ch_d;
         s2_add_q    <= s2_add_d;
         s2_clr_q    <= s2_clr_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         ch_out_q    <= ch_out_d;
         res_q       <= res_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign ch_out    = ch_out_q;
   assign RES       = res_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_v_mac_multichan.sv
// Scoreboard bench: four differently-parameterised MACs share one stimulus stream;
// an integer model predicts each result, checked in order against the DUT outputs.
module tb_v_mac_multichan;

   typedef struct {
      logic [1:0]  ch;
      logic [19:0] res;
      logic        ovf;
      int          due;
   } exp_t;

   logic       clk, rst_n, in_valid, add_sub, clr;
   logic [1:0] ch;
   logic [7:0] a, b;

   logic        ov0, ov1, ov2, ov3, of0, of1, of2, of3;
   logic [1:0]  cho0, cho1, cho2, cho3;
   logic [19:0] res0, res1, res3;
   logic [15:0] res2;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t q0[$], q1[$], q2[$], q3[$];
   longint macc [4][4];
   logic [19:0] last_res [4];
   logic [1:0]  last_ch [4];
   logic        last_ovf [4];

   // u0 defaults, u1 unsigned saturating, u2 signed saturating 16-bit, u3 three channels
   v_mac_multichan u0 (.clk(clk), .reset(rst_n), .in_valid(in_valid), .ch(ch), .add_sub(add_sub),
      .clr(clr), .A(a), .B(b), .out_valid(ov0), .ch_out(cho0), .RES(res0), .ovf(of0));
   v_mac_multichan #(.SATURATE(1'b1)) u1 (.clk(clk), .reset(rst_n), .in_valid(in_valid), .ch(ch),
      .add_sub(add_sub), .clr(clr), .A(a), .B(b), .out_valid(ov1), .ch_out(cho1), .RES(res1), .ovf(of1));
   v_mac_multichan #(.SIGNED(1'b1), .SATURATE(1'b1), .WACC(16)) u2 (.clk(clk), .reset(rst_n),
      .in_valid(in_valid), .ch(ch), .add_sub(add_sub), .clr(clr), .A(a), .B(b), .out_valid(ov2),
      .ch_out(cho2), .RES(res2), .ovf(of2));
   v_mac_multichan #(.CHANNELS(3)) u3 (.clk(clk), .reset(rst_n), .in_valid(in_valid), .ch(ch),
      .add_sub(add_sub), .clr(clr), .A(a), .B(b), .out_valid(ov3), .ch_out(cho3), .RES(res3), .ovf(of3));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push(input int inst, input exp_t e);
      case (inst)
         0: q0.push_back(e);
         1: q1.push_back(e);
         2: q2.push_back(e);
         default: q3.push_back(e);
      endcase
   endtask

   // Reference arithmetic on wide integers, independent of the RTL bit tricks.
   task automatic model_op(input int inst, input logic [1:0] c, input logic as, input logic cl,
                           input logic [7:0] av8, input logic [7:0] bv8);
      longint w, m, lo, hi, av, bv, p, base, t;
      bit sg, sat;
      int nch;
      exp_t e;
      w   = (inst == 2) ? 16 : 20;
      sg  = (inst == 2);
      sat = (inst == 1) || (inst == 2);
      nch = (inst == 3) ? 3 : 4;
      if (int'(c) >= nch) return;
      if (sg) begin
         av = longint'($signed(av8));
         bv = longint'($signed(bv8));
      end else begin
         av = longint'(av8);
         bv = longint'(bv8);
      end
      p  = av * bv;
      m  = longint'(1) << w;
      lo = sg ? -(m / 2) : 0;
      hi = sg ? (m / 2 - 1) : (m - 1);
      base = cl ? 0 : macc[inst][c];
      t = as ? base + p : base - p;
      e.ovf = (t < lo) || (t > hi);
      if (e.ovf) begin
         if (sat) t = (t > hi) ? hi : lo;
         else begin
            t = t & (m - 1);
            if (sg && t > hi) t = t - m;
         end
      end
      macc[inst][c] = t;
      e.res = 20'(t & (m - 1));
      e.ch  = c;
      e.due = cyc + 3;
      push(inst, e);
   endtask

   task automatic mon(input int inst, input logic v, input logic [19:0] r, input logic [1:0] c,
                      input logic o);
      exp_t e;
      bit   have;
      if (!rst_n) begin
         last_res[inst] = r;
         last_ch[inst]  = c;
         last_ovf[inst] = o;
      end else if (v) begin
         have = 0;
         case (inst)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
            2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1; end
         endcase
         if (!have) check($sformatf("u%0d_spurious_valid", inst), 1, 0);
         else begin
            check($sformatf("u%0d_res", inst), r, e.res);
            check($sformatf("u%0d_ch_out", inst), c, e.ch);
            check($sformatf("u%0d_ovf", inst), o, e.ovf);
            check($sformatf("u%0d_latency", inst), cyc, e.due);
         end
         last_res[inst] = r;
         last_ch[inst]  = c;
         last_ovf[inst] = o;
      end else begin
         check($sformatf("u%0d_hold_res", inst), r, last_res[inst]);
         check($sformatf("u%0d_hold_ch", inst), c, last_ch[inst]);
         check($sformatf("u%0d_hold_ovf", inst), o, last_ovf[inst]);
      end
   endtask

   task automatic monitor_loop();
      forever begin
         @(negedge clk);
         mon(0, ov0, res0, cho0, of0);
         mon(1, ov1, res1, cho1, of1);
         mon(2, ov2, {4'b0, res2}, cho2, of2);
         mon(3, ov3, res3, cho3, of3);
      end
   endtask

   task automatic flush_model();
      q0.delete();
      q1.delete();
      q2.delete();
      q3.delete();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) macc[i][j] = 0;
   endtask

   task automatic check_reset_outputs();
      check("rst_out_valid", {ov0, ov1, ov2, ov3}, 0);
      check("rst_ch_out", {cho0, cho1, cho2, cho3}, 0);
      check("rst_ovf", {of0, of1, of2, of3}, 0);
      check("rst_res0", res0, 0);
      check("rst_res1", res1, 0);
      check("rst_res2", res2, 0);
      check("rst_res3", res3, 0);
   endtask

   task automatic drive(input logic [1:0] c, input logic as, input logic cl,
                        input logic [7:0] av, input logic [7:0] bv);
      @(negedge clk);
      #1;
      ch = c; add_sub = as; clr = cl; a = av; b = bv; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) model_op(i, c, as, cl, av, bv);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      in_valid = 1'b0;
      flush_model();
      #1;
      check_reset_outputs();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; ch = '0; add_sub = 1'b1; clr = 1'b0; a = '0; b = '0;
      flush_model();
      fork
         monitor_loop();
      join_none
      #3;
      check_reset_outputs();
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;

      // Single channel: 12 then 42
      drive(2'd0, 1'b1, 1'b0, 8'd3, 8'd4);
      drive(2'd0, 1'b1, 1'b0, 8'd5, 8'd6);
      idle(5);

      // Channel isolation and clear: ch0 100,200 / ch1 100 / ch0 clr -> 4
      do_reset();
      drive(2'd0, 1'b1, 1'b0, 8'd10, 8'd10);
      drive(2'd1, 1'b1, 1'b0, 8'd10, 8'd10);
      drive(2'd0, 1'b1, 1'b0, 8'd10, 8'd10);
      drive(2'd0, 1'b1, 1'b1, 8'd2, 8'd2);
      idle(5);

      // Subtract below zero: wraps on u0, clamps on u1
      do_reset();
      drive(2'd0, 1'b0, 1'b0, 8'd1, 8'd1);
      idle(5);

      // Signed saturation up on ch0, down on ch1 (-32768 is reachable without overflow)
      do_reset();
      repeat (3) drive(2'd0, 1'b1, 1'b0, 8'h80, 8'h80);
      repeat (3) drive(2'd1, 1'b0, 1'b0, 8'h80, 8'h80);
      idle(5);

      // Reset mid-operation: two ops in flight and a third sampled during reset are lost
      drive(2'd2, 1'b1, 1'b0, 8'd9, 8'd9);
      drive(2'd2, 1'b1, 1'b0, 8'd8, 8'd8);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      ch = 2'd2; add_sub = 1'b1; clr = 1'b0; a = 8'd6; b = 8'd6; in_valid = 1'b1;
      flush_model();
      #1;
      check_reset_outputs();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      in_valid = 1'b0;
      idle(4);
      drive(2'd2, 1'b1, 1'b0, 8'd7, 8'd7);
      drive(2'd0, 1'b1, 1'b0, 8'd0, 8'd0);
      drive(2'd1, 1'b1, 1'b0, 8'd0, 8'd0);
      idle(5);

      // Invalid channel on u3, then alternating bubbles
      drive(2'd0, 1'b1, 1'b0, 8'd2, 8'd3);
      drive(2'd3, 1'b1, 1'b0, 8'd5, 8'd5);
      drive(2'd3, 1'b1, 1'b0, 8'd1, 8'd1);
      drive(2'd0, 1'b1, 1'b0, 8'd0, 8'd0);
      for (int i = 0; i < 6; i++) begin
         drive(2'(i % 4), 1'b1, 1'b0, 8'(i + 1), 8'd3);
         idle(1);
      end
      idle(5);

      // Random mix: bubbles, clears, both directions, all channels
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         else drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)));
      end
      idle(6);

      check("u0_left_in_queue", q0.size(), 0);
      check("u1_left_in_queue", q1.size(), 0);
      check("u2_left_in_queue", q2.size(), 0);
      check("u3_left_in_queue", q3.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
